fxp_pwm_driver: RTL
===================

Name: fxp_pwm_driver

Overview:
- Actuator-side end of the control loop. Accepts signed Q(N-Q).Q control words from the PID stage over a valid/ready handshake.
- Clamps each word to [0, 1.0] and scales it to a duty count.
- Drives a fixed-period PWM output, updating the duty only at period boundaries (glitch-free).
- Emits a period_start strobe that the loop uses as its sampling trigger.

Parameters:
- N, 32, control word width.
- Q, 18, fractional bits of the control word.
- CNT_W, 12, PWM counter width.
- PERIOD, 4000, PWM period in clk cycles; 2 <= PERIOD <= 2^CNT_W - 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- en  in  1  PWM enable.
- u_data  in  N  signed control word, Q(N-Q).Q.
- u_valid  in  1  u_data valid.
- u_ready  out  1  block can accept a word this cycle.
- pwm_out  out  1  PWM output, registered.
- period_start  out  1  one-cycle strobe on the first clock of each period.
- duty_active  out  CNT_W  duty count currently driving pwm_out.
- sat_hi  out  1  last converted word was clamped to 1.0 (sticky until next conversion).
- sat_lo  out  1  last converted word was clamped to 0 (sticky until next conversion).

Behaviour:
- Reset state: cnt=0, duty_active=0, duty_pending=0, pending_vld=0, busy=0, pwm_out=0, period_start=0, u_ready=1, sat_hi=0, sat_lo=0.
- Handshake and acceptance:
  - u_ready = !busy.
  - A transfer occurs on an edge where u_valid & u_ready.
  - busy sets on the transfer edge and clears two edges later.
  - Maximum acceptance rate is one word per 3 cycles.
  - u_data is ignored while u_ready=0.
- Conversion pipeline (accept at edge k):
  - Edge k+1, stage 1 (clamp):
    - u < 0: uc=0, sat_lo=1.
    - u > ONE_Q (1<<Q): uc=ONE_Q, sat_hi=1.
    - Otherwise: uc=u, both flags 0.
    - uc is unsigned, Q+1 bits.
  - Edge k+2, stage 2 (scale):
    - duty_pending = (uc * PERIOD) >> Q, truncated.
    - Product is Q+1+CNT_W bits; the result fits CNT_W bits, no overflow possible.
    - pending_vld=1.
- Counter:
  - When en=1: cnt increments every clock and wraps PERIOD-1 -> 0.
  - When en=0: cnt held at 0, pwm_out=0, period_start=0, duty_active unchanged.
  - Conversions still proceed while en=0.
- Period boundary (wrap edge, or first edge after en rises):
  - If pending_vld: duty_active <= duty_pending and pending_vld <= 0.
  - Otherwise duty_active is kept.
- Output alignment:
  - pwm_out and period_start are registered from the same cnt/duty state, so they are aligned.
  - period_start=1 in the cycle where cnt=0.
  - pwm_out=1 in cycles where cnt < duty_active, using the duty loaded at that boundary.
  - duty_active=0: pwm_out never high.
  - duty_active=PERIOD: pwm_out constantly high, no gap.
- Simultaneous events:
  - If stage 2 writes duty_pending on the same edge as a boundary, the boundary takes the OLD duty_pending (if pending_vld). The new value stays pending for the next period.
  - A new conversion overwrites an unapplied duty_pending: latest wins. There is no FIFO.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). Any in-flight conversion is discarded.
- Latency: a word accepted at edge k affects pwm_out from the first period boundary at or after edge k+3.

Decomposition:
- Shared package fxp_pkg holds:
  - N_DEF=32, Q_DEF=18.
  - ONE_Q = 1<<Q.
  - A saturating-clamp function reused by the PID and Kalman blocks.
- Sub-module fxp_sat_scale implements the two-stage clamp+scale pipeline. Its interface is:
  - in_valid, u, out_valid, duty, sat_hi, sat_lo.
- fxp_pwm_driver itself holds the handshake, pending/active registers, counter and outputs.

Test Plan (PERIOD=100, CNT_W=8 unless noted):
- Reset then en=1 with no input -> pwm_out stays 0; period_start pulses every 100 cycles; u_ready=1.
- Send u=0x0002_0000 (0.5) -> u_ready low for 2 cycles. From the next boundary: duty_active=50, pwm_out high for exactly 50 of 100 cycles, high at cnt=0. Both sat flags 0.
- Send u=0xFFFC_0000 (-1.0) -> duty 0, sat_lo=1, pwm_out never high. Then send u=0x000C_0000 (3.0) -> duty 100, sat_hi=1, sat_lo=0, pwm_out high all 100 cycles.
- Send 0.25 then 0.75 within one period, with no boundary between them -> only 75 is applied at the next boundary; 25 never appears. Send a word whose stage 2 completes exactly on the wrap edge -> old pending is applied and the new one appears one period later.
- Hold u_valid=1 continuously with changing data -> transfers occur every 3rd cycle only; data presented while u_ready=0 has no effect.
- Assert reset at cnt=37 with duty 50 and a conversion in flight -> all outputs return to reset values that cycle. After release with en=1: cnt restarts at 0 and the discarded word is never applied.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the control-loop datapath.
// Q-format defaults and the saturating clamp used by PID, Kalman and PWM.
package fxp_pkg;

    localparam int N_DEF = 32;
    localparam int Q_DEF = 18;
    localparam int ONE_Q = 1 << Q_DEF;

    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/fxp_sat_scale.sv
// Two-stage pipeline: clamp a signed Q word to [0, 1.0], then scale
// it to a PWM duty count. Saturation flags stick until the next word.
module fxp_sat_scale
    import fxp_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int Q      = Q_DEF,
    parameter int CNT_W  = 12,
    parameter int PERIOD = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     u,
    output logic             out_valid,
    output logic [CNT_W-1:0] duty,
    output logic             sat_hi,
    output logic             sat_lo
);

    localparam logic signed [63:0] ONE_L = 64'sd1 <<< Q;
    localparam int PW = Q + CNT_W;

    logic signed [63:0] u_ext;
    logic signed [63:0] u_clamp;
    logic [Q:0]         uc;
    logic               s1_vld;
    logic [PW-1:0]      prod;

    assign u_ext   = {{(64-N){u[N-1]}}, u};
    assign u_clamp = sat_clamp(u_ext, 64'sd0, ONE_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uc     <= '0;
            s1_vld <= 1'b0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                uc     <= (Q+1)'(u_clamp);
                sat_hi <= (u_ext > ONE_L);
                sat_lo <= (u_ext < 64'sd0);
            end
        end
    end

    // uc <= 2^Q, so uc*PERIOD always fits in Q+CNT_W bits
    assign prod      = PW'(uc) * PW'(PERIOD);
    assign duty      = CNT_W'(prod >> Q);
    assign out_valid = s1_vld;

endmodule

// File: rtl/fxp_pwm_driver.sv
// Actuator end of the control loop: accepts clamped/scaled control
// words and drives a fixed-period PWM updated only at period boundaries.
module fxp_pwm_driver
    import fxp_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int Q      = Q_DEF,
    parameter int CNT_W  = 12,
    parameter int PERIOD = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     u_data,
    input  logic             u_valid,
    output logic             u_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_active,
    output logic             sat_hi,
    output logic             sat_lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [1:0]       busy_cnt;
    logic             xfer;
    logic             xfer_d;
    logic [N-1:0]     u_reg;
    logic             s2_vld;
    logic [CNT_W-1:0] s2_duty;
    logic [CNT_W-1:0] duty_pending;
    logic             pending_vld;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] duty_nxt;
    logic             running;
    logic             run_nxt;
    logic             boundary;

    assign u_ready = (busy_cnt == 2'd0);
    assign xfer    = u_valid && u_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt <= 2'd0;
            xfer_d   <= 1'b0;
            u_reg    <= '0;
        end else begin
            xfer_d <= xfer;
            if (xfer) begin
                busy_cnt <= 2'd2;
                u_reg    <= u_data;
            end else if (busy_cnt != 2'd0) begin
                busy_cnt <= busy_cnt - 2'd1;
            end
        end
    end

    fxp_sat_scale #(
        .N      (N),
        .Q      (Q),
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_sat_scale (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (xfer_d),
        .u         (u_reg),
        .out_valid (s2_vld),
        .duty      (s2_duty),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo)
    );

    // First enabled edge after idle starts a fresh period at cnt=0
    always_comb begin
        cnt_nxt  = cnt;
        run_nxt  = running;
        boundary = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
            run_nxt = 1'b0;
        end else if (!running || cnt == LAST) begin
            cnt_nxt  = '0;
            run_nxt  = 1'b1;
            boundary = 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        duty_nxt = duty_active;
        if (boundary && pending_vld) begin
            duty_nxt = duty_pending;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            running      <= 1'b0;
            duty_active  <= '0;
            duty_pending <= '0;
            pending_vld  <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            running      <= run_nxt;
            duty_active  <= duty_nxt;
            pwm_out      <= en && (cnt_nxt < duty_nxt);
            period_start <= boundary;
            // A word landing on a boundary edge waits for the next one
            if (s2_vld) begin
                duty_pending <= s2_duty;
                pending_vld  <= 1'b1;
            end else if (boundary) begin
                pending_vld <= 1'b0;
            end
        end
    end

endmodule
